// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces the three board keys, runs the
// IDLE/RUNNING/PAUSED machine and produces the tick, clear and display-enable strobes.
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_reset,
  input  logic key_start_pause,
  input  logic key_display_stop,
  output logic tick_10ms,
  output logic clear,
  output logic display_live,
  output logic counter_work,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam int PSW = $clog2(TICK_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2
  } state_e;

  // Key lanes: bit 0 = reset, bit 1 = start/pause, bit 2 = display freeze.
  logic [2:0]     keys;
  logic [2:0]     sync1_q;
  logic [2:0]     sync2_q;
  logic [2:0]     db_q;
  logic [2:0]     db_dly_q;
  logic [2:0]     press_q;
  logic [DBW-1:0] dbcnt_q [3];

  assign keys = {key_display_stop, key_start_pause, key_reset};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      db_q     <= '1;
      db_dly_q <= '1;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) dbcnt_q[i] <= '0;
    end else begin
      sync1_q  <= keys;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      // One-cycle event the cycle after the debounced level falls.
      press_q  <= db_dly_q & ~db_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          dbcnt_q[i] <= '0;
        end else if (dbcnt_q[i] == DB_LAST) begin
          db_q[i]    <= sync2_q[i];
          dbcnt_q[i] <= '0;
        end else begin
          dbcnt_q[i] <= dbcnt_q[i] + 1'b1;
        end
      end
    end
  end

  state_e         state_q, state_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic           tick_q, tick_d;
  logic           clear_q, clear_d;
  logic           live_q, live_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clear_q <= 1'b0;
      live_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clear_q <= clear_d;
      live_q  <= live_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    clear_d = 1'b0;
    live_d  = live_q;
    if (press_q[0]) begin
      // A clear command overrides any other key event in the same cycle.
      state_d = S_IDLE;
      presc_d = '0;
      clear_d = 1'b1;
      live_d  = 1'b1;
    end else begin
      if (press_q[2]) live_d = ~live_q;
      case (state_q)
        S_IDLE: begin
          if (press_q[1]) begin
            state_d = S_RUNNING;
            presc_d = '0;
          end
        end
        S_RUNNING: begin
          if (press_q[1]) begin
            state_d = S_PAUSED;
          end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSED: begin
          if (press_q[1]) state_d = S_RUNNING;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign tick_10ms    = tick_q;
  assign clear        = clear_q;
  assign display_live = live_q;
  assign counter_work = (state_q == S_RUNNING);
  assign led0         = (state_q == S_RUNNING);
  assign led1         = (state_q == S_PAUSED);
  assign led2         = ~live_q;
  assign led3         = ~(&db_q);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a cycle model pushes expected outputs at each rising
// edge, and they are popped and compared against the DUT on the falling edge.
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam int T = 5;

  logic clk = 1'b0;
  logic reset;
  logic key_reset, key_start_pause, key_display_stop;
  logic tick_10ms, clear, display_live, counter_work;
  logic led0, led1, led2, led3;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_reset        (key_reset),
    .key_start_pause  (key_start_pause),
    .key_display_stop (key_display_stop),
    .tick_10ms        (tick_10ms),
    .clear            (clear),
    .display_live     (display_live),
    .counter_work     (counter_work),
    .led0             (led0),
    .led1             (led1),
    .led2             (led2),
    .led3             (led3)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "rst";

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference model
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  logic [7:0] sb[$];
  logic [2:0] pins;
  int   m_state, m_presc;
  bit   m_tick, m_clr, m_live;
  bit   m_s1[3], m_s2[3], m_db[3], m_dbd[3], m_press[3];
  int   m_cnt[3];

  assign pins = {key_display_stop, key_start_pause, key_reset};

  always @(posedge clk) begin
    if (reset) begin
      m_state = M_IDLE; m_presc = 0; m_tick = 0; m_clr = 0; m_live = 1;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1; m_s2[i] = 1; m_db[i] = 1; m_dbd[i] = 1; m_press[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      m_tick = 0;
      m_clr  = 0;
      if (m_press[0]) begin
        m_state = M_IDLE; m_presc = 0; m_clr = 1; m_live = 1;
      end else begin
        if (m_press[2]) m_live = !m_live;
        if (m_press[1]) begin
          if (m_state == M_RUN) m_state = M_PAUSE;
          else begin
            if (m_state == M_IDLE) m_presc = 0;
            m_state = M_RUN;
          end
        end else if (m_state == M_RUN) begin
          if (m_presc == T - 1) begin m_presc = 0; m_tick = 1; end
          else m_presc++;
        end
      end
      for (int i = 0; i < 3; i++) begin
        m_press[i] = m_dbd[i] && !m_db[i];
        m_dbd[i]   = m_db[i];
        if (m_s2[i] != m_db[i]) begin
          if (m_cnt[i] == D - 1) begin m_db[i] = m_s2[i]; m_cnt[i] = 0; end
          else m_cnt[i]++;
        end else m_cnt[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = pins[i];
      end
    end
    sb.push_back({m_tick, m_clr, m_live, m_state == M_RUN, m_state == M_RUN,
                  m_state == M_PAUSE, !m_live, !(m_db[0] && m_db[1] && m_db[2])});
  end

  int n_ticks = 0, n_clr = 0, n_cw = 0;

  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      check_eq(phase, {24'd0, tick_10ms, clear, display_live, counter_work,
                       led0, led1, led2, led3}, {24'd0, exp_v});
    end
    if (tick_10ms === 1'b1) n_ticks++;
    if (clear === 1'b1) n_clr++;
    if (counter_work === 1'b1) n_cw++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int t0, c0, w0;

  initial begin
    reset = 1'b1;
    key_reset = 1'b1; key_start_pause = 1'b1; key_display_stop = 1'b1;
    cyc(3);
    reset = 1'b0;

    phase = "idle";
    t0 = n_ticks;
    cyc(50);
    check_eq("idle_ticks", n_ticks - t0, 0);

    phase = "bounce";
    key_start_pause = 1'b0; cyc(3);
    key_start_pause = 1'b1; cyc(1);
    key_start_pause = 1'b0; cyc(3);
    key_start_pause = 1'b1; cyc(15);
    check_eq("bounce_cw", counter_work, 0);
    check_eq("bounce_led1", led1, 0);

    phase = "start";
    key_start_pause = 1'b0;
    cyc(7);
    check_eq("cw_before", counter_work, 0);
    cyc(1);
    check_eq("cw_after", counter_work, 1);
    t0 = n_ticks;
    cyc(12);
    key_start_pause = 1'b1;
    cyc(3);
    check_eq("run_ticks", n_ticks - t0, 3);
    cyc(10);

    phase = "pause";
    key_start_pause = 1'b0; cyc(8); key_start_pause = 1'b1;
    check_eq("paused", led1, 1);
    t0 = n_ticks;
    cyc(30);
    check_eq("pause_ticks", n_ticks - t0, 0);
    phase = "resume";
    key_start_pause = 1'b0; cyc(8); key_start_pause = 1'b1;
    check_eq("resumed", counter_work, 1);
    cyc(20);

    phase = "freeze";
    key_display_stop = 1'b0; cyc(8); key_display_stop = 1'b1;
    check_eq("frozen", display_live, 0);
    t0 = n_ticks;
    cyc(15);
    check_eq("frz_ticking", (n_ticks - t0) > 0, 1);
    phase = "clrkey";
    c0 = n_clr;
    key_reset = 1'b0; cyc(8); key_reset = 1'b1;
    cyc(5);
    check_eq("clr_pulses", n_clr - c0, 1);
    check_eq("clr_live", display_live, 1);
    check_eq("clr_cw", counter_work, 0);
    t0 = n_ticks;
    cyc(20);
    check_eq("clr_ticks", n_ticks - t0, 0);

    phase = "coinc";
    key_start_pause = 1'b0; cyc(8); key_start_pause = 1'b1; cyc(10);
    key_start_pause = 1'b0; cyc(8); key_start_pause = 1'b1; cyc(10);
    check_eq("coinc_paused", led1, 1);
    c0 = n_clr;
    w0 = n_cw;
    key_reset = 1'b0; key_start_pause = 1'b0;
    cyc(8);
    key_reset = 1'b1; key_start_pause = 1'b1;
    cyc(10);
    check_eq("coinc_clr", n_clr - c0, 1);
    check_eq("coinc_cw", n_cw - w0, 0);
    check_eq("coinc_idle", led1, 0);

    phase = "midrst";
    key_start_pause = 1'b0; cyc(8); key_start_pause = 1'b1; cyc(12);
    key_display_stop = 1'b0; cyc(3);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check_eq("midrst_cw", counter_work, 0);
    check_eq("midrst_live", display_live, 1);
    cyc(4);
    key_display_stop = 1'b1;
    cyc(15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the DE1-SoC stopwatch datapath (6-digit mm:ss:cc counter/display register bank). It debounces the three active-low board keys and runs the IDLE/RUNNING/PAUSED state machine. It also generates the 10 ms count-enable tick, the counter-clear pulse and the live/frozen display-update enable. The BCD counter chain consumes tick_10ms and clear. The display register bank copies counters while display_live=1. LEDs show controller status.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronized key level must differ from the debounced level before it is accepted (20 ms at 50 MHz); must be at least 2
TICK_CYCLES, 500000, clk cycles per 10 ms tick (50 MHz); must be at least 2

Ports:
clk  input  1  50 MHz system clock; all logic on rising edge
reset  input  1  synchronous, active-high controller reset
key_reset  input  1  raw board key, 0 = pressed; "clear stopwatch" command
key_start_pause  input  1  raw board key, 0 = pressed; start/pause toggle
key_display_stop  input  1  raw board key, 0 = pressed; freeze/unfreeze display toggle
tick_10ms  output  1  one-cycle count-enable pulse to the counter chain; only in RUNNING
clear  output  1  one-cycle pulse that zeroes all six counter digits
display_live  output  1  1 = display registers follow counters; 0 = display held
counter_work  output  1  1 while state = RUNNING
led0  output  1  RUNNING indicator
led1  output  1  PAUSED indicator
led2  output  1  display frozen (= ~display_live)
led3  output  1  1 while any debounced key is held down

Behaviour:
- One clock and one reset: clk, with reset synchronous and active-high. Every register is set to its reset value on the first rising edge of clk at which reset=1.
- Reset values: state=IDLE, display_live=1, tick_10ms=0, clear=0, counter_work=0, led0..led3=0, prescaler=0, debounce counters=0, synchronizers=1, debounced levels=1 (released), press pulses=0.
- Key path, per key, three identical instances:
  - Two-flop synchronizer; s is the second flop.
  - Debounce counter: increments while s != db and clears to 0 while s == db.
  - When the counter equals DEBOUNCE_CYCLES-1 and s != db, then db <= s and the counter <= 0.
  - press is a registered pulse, high for exactly one cycle, on the cycle after db goes 1->0. A release (db 0->1) produces no event.
- Latency: let k be the first edge that samples the pin low, with the pin held low throughout.
  - db falls at edge k+1+DEBOUNCE_CYCLES.
  - press is high after edge k+2+DEBOUNCE_CYCLES.
  - State and outputs change at edge k+3+DEBOUNCE_CYCLES.
- Bounce rejection: any return of s to db before the count completes restarts the count. A key held at reset release is reported as a press once it has been debounced.
- FSM transitions, evaluated on press pulses:
  - IDLE: start press -> RUNNING, with prescaler=0.
  - RUNNING: start press -> PAUSED; the prescaler holds its value.
  - PAUSED: start press -> RUNNING; the prescaler resumes from the held value.
  - Any state: reset press -> IDLE, clear=1 for one cycle, prescaler=0, display_live=1.
  - Any state: display press toggles display_live, with no state change.
- Priority when press pulses coincide in one cycle: the reset press wins and start/display presses in that cycle are discarded. A start press together with a display press applies both.
- Prescaler: counts 0..TICK_CYCLES-1 only in RUNNING. At TICK_CYCLES-1 it wraps to 0 and tick_10ms=1 for that one cycle. The first tick after IDLE->RUNNING is exactly TICK_CYCLES cycles after the state change. tick_10ms is never high outside RUNNING, including the cycle of a pause transition.
- Status outputs: counter_work=led0=(state==RUNNING), led1=(state==PAUSED), led2=~display_live, led3=~(db_reset & db_start & db_display).
- Reset asserted mid-operation returns all outputs to reset values on that edge. An in-progress debounce count is discarded.

Test Plan:
Run with DEBOUNCE_CYCLES=4 and TICK_CYCLES=5; all keys are high unless stated.
1. Hold reset=1 for 3 cycles, then release -> state IDLE, display_live=1, tick_10ms=clear=counter_work=led0..3=0, no ticks for 50 cycles.
2. Drive key_start_pause low from edge k for 20 cycles -> counter_work=1 at edge k+7; tick_10ms pulses at k+12, k+17, k+22, each one cycle wide; led3=1 from edge k+5.
3. Bounce on key_start_pause: low 3 cycles, high 1, low 3, then high -> no press, state stays IDLE, no tick.
4. In RUNNING with prescaler=2, press start -> PAUSED, no ticks for 30 cycles; press start again -> first tick 3 cycles after re-entering RUNNING, then every 5 cycles.
5. RUNNING, press display -> display_live=0 and led2=1 while ticks continue; press reset -> clear high exactly 1 cycle, IDLE, display_live=1, ticks stop.
6. Force reset press and start press on the same cycle while PAUSED -> IDLE, clear=1 for one cycle, counter_work stays 0.
